// File: rtl/stream_demux_pkg.sv
// Shared defaults and helpers for the one-to-N stream demultiplexer.
package stream_demux_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 4;

  // Select width never collapses to zero bits, even for a single channel.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_slot.sv
// One-entry downstream output register; reports "free" when it can take a beat this cycle,
// including the drain-and-refill case where the consumer takes the current beat.
module stream_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);
  assign free = ~valid | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready stream to one of N registered channels by explicit select or round-robin.
// One cycle latency to the channel; up_ready follows the target slot's free flag combinationally.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  localparam int SW   = sel_w(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      up_valid,
  output logic                      up_ready,
  input  logic [WIDTH-1:0]          up_data,
  input  logic [SW-1:0]             up_sel,
  input  logic                      mode,
  output logic [N-1:0]              dn_valid,
  input  logic [N-1:0]              dn_ready,
  output logic [N-1:0][WIDTH-1:0]   dn_data,
  output logic                      err,
  output logic [15:0]               beat_cnt
);
  localparam logic [SW:0]   N_EXT = (SW+1)'(N);
  localparam logic [SW-1:0] LAST  = SW'(N-1);

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] tgt;
  logic [N-1:0]  free;
  logic [N-1:0]  load;
  logic          in_range;
  logic          accept;

  assign tgt      = mode ? rr_ptr : up_sel;
  assign in_range = ({1'b0, tgt} < N_EXT);
  // Out-of-range selects are swallowed so a bad producer can never stall the stream.
  assign up_ready = in_range ? free[tgt] : 1'b1;
  assign accept   = up_valid & up_ready & ~rst;

  always_comb begin
    load = '0;
    if (accept && in_range) load[tgt] = 1'b1;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[gi]),
      .load_data (up_data),
      .ready     (dn_ready[gi]),
      .valid     (dn_valid[gi]),
      .data      (dn_data[gi]),
      .free      (free[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      err      <= 1'b0;
      beat_cnt <= '0;
    end else begin
      err <= accept & ~in_range;
      if (accept && in_range) beat_cnt <= beat_cnt + 16'd1;
      if (accept && mode) rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench: N=4 instance against a per-channel reference model, N=3 instance for out-of-range selects.
module tb_stream_demux;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            up_valid = 1'b0;
  logic            up_ready;
  logic [7:0]      up_data = '0;
  logic [1:0]      up_sel = '0;
  logic            mode = 1'b0;
  logic [3:0]      dn_valid;
  logic [3:0]      dn_ready = '0;
  logic [3:0][7:0] dn_data;
  logic            err;
  logic [15:0]     beat_cnt;

  logic            b_rst = 1'b1;
  logic            b_up_valid = 1'b0;
  logic            b_up_ready;
  logic [7:0]      b_up_data = '0;
  logic [1:0]      b_up_sel = '0;
  logic            b_mode = 1'b0;
  logic [2:0]      b_dn_valid;
  logic [2:0]      b_dn_ready = '1;
  logic [2:0][7:0] b_dn_data;
  logic            b_err;
  logic [15:0]     b_beat_cnt;

  int ncmp = 0;
  int nfail = 0;

  // Reference model: what each channel holds, the round-robin position and the beat count.
  bit        mv[4];
  logic [7:0] mdat[4];
  int        mrr = 0;
  int        mcnt = 0;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_sel(up_sel), .mode(mode), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .dn_data(dn_data), .err(err), .beat_cnt(beat_cnt)
  );

  stream_demux #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(b_rst), .up_valid(b_up_valid), .up_ready(b_up_ready), .up_data(b_up_data),
    .up_sel(b_up_sel), .mode(b_mode), .dn_valid(b_dn_valid), .dn_ready(b_dn_ready),
    .dn_data(b_dn_data), .err(b_err), .beat_cnt(b_beat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check up_ready, advance the model, then check the registered outputs.
  task automatic cyc(input logic v, input logic [7:0] d, input int s, input logic m,
                     input logic [3:0] rd, input logic r);
    int   t;
    bit   ur;
    bit   acc;
    logic [3:0] ev;
    up_valid = v; up_data = d; up_sel = s[1:0]; mode = m; dn_ready = rd; rst = r;
    #1;
    t  = m ? mrr : s;
    ur = !mv[t] || rd[t];
    chk("up_ready", {31'd0, up_ready}, {31'd0, ur});
    acc = v && ur && !r;
    for (int k = 0; k < 4; k++) if (mv[k] && rd[k]) mv[k] = 0;
    if (r) begin
      for (int k = 0; k < 4; k++) begin mv[k] = 0; mdat[k] = 8'h00; end
      mrr = 0;
      mcnt = 0;
    end else if (acc) begin
      mv[t] = 1;
      mdat[t] = d;
      mcnt = (mcnt + 1) % 65536;
      if (m) mrr = (mrr + 1) % 4;
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) ev[k] = mv[k];
    chk("dn_valid", {28'd0, dn_valid}, {28'd0, ev});
    chk("dn_data", dn_data, {mdat[3], mdat[2], mdat[1], mdat[0]});
    chk("err", {31'd0, err}, 32'd0);
    chk("beat_cnt", {16'd0, beat_cnt}, mcnt);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin mv[k] = 0; mdat[k] = 8'h00; end
    @(negedge clk);

    // Reset then idle, up_sel=2 must be ready.
    cyc(0, 8'h00, 2, 0, 4'hF, 1);
    cyc(0, 8'h00, 2, 0, 4'hF, 0);
    chk("reset_valid", {28'd0, dn_valid}, 32'd0);

    // Explicit select to 3,0,1,2.
    cyc(1, 8'hA0, 3, 0, 4'hF, 0);
    chk("explicit_ch3", {28'd0, dn_valid}, 32'h8);
    cyc(1, 8'hA1, 0, 0, 4'hF, 0);
    cyc(1, 8'hA2, 1, 0, 4'hF, 0);
    cyc(1, 8'hA3, 2, 0, 4'hF, 0);
    chk("explicit_ch2", {28'd0, dn_valid}, 32'h4);
    chk("explicit_cnt", {16'd0, beat_cnt}, 32'd4);
    cyc(0, 8'h00, 0, 0, 4'hF, 0);

    // Back-pressure on channel 1, then release with refill in the same cycle.
    cyc(1, 8'h11, 1, 0, 4'b1101, 0);
    cyc(1, 8'h22, 1, 0, 4'b1101, 0);
    chk("bp_hold", {24'd0, dn_data[1]}, 32'h11);
    cyc(1, 8'h22, 1, 0, 4'hF, 0);
    chk("bp_refill", {24'd0, dn_data[1]}, 32'h22);
    cyc(0, 8'h00, 0, 0, 4'hF, 0);

    // Round-robin: six beats, detour through explicit mode, then resume.
    for (int i = 1; i <= 6; i++) cyc(1, 8'(i), 0, 1, 4'hF, 0);
    chk("rr_sixth", {28'd0, dn_valid}, 32'h2);
    cyc(1, 8'h40, 0, 0, 4'hF, 0);
    cyc(1, 8'h41, 0, 1, 4'hF, 0);
    chk("rr_resume", {28'd0, dn_valid}, 32'h4);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 49) == 0));

    // Reset while channels 0 and 2 are stalled.
    cyc(0, 8'h00, 0, 0, 4'hF, 1);
    cyc(1, 8'hC0, 0, 0, 4'h0, 0);
    cyc(1, 8'hC2, 2, 0, 4'h0, 0);
    chk("midop_held", {28'd0, dn_valid}, 32'h5);
    cyc(0, 8'h00, 0, 0, 4'h0, 1);
    chk("midop_cnt", {16'd0, beat_cnt}, 32'd0);
    cyc(1, 8'hD0, 0, 1, 4'hF, 0);
    chk("midop_after", {28'd0, dn_valid}, 32'h1);
    chk("midop_data", {24'd0, dn_data[0]}, 32'hD0);

    // N=3: out-of-range select is swallowed with a one-cycle err pulse.
    @(posedge clk); @(negedge clk);
    b_rst = 1'b0; b_mode = 1'b0; b_up_sel = 2'd3; b_up_data = 8'h55; b_up_valid = 1'b1;
    #1;
    chk("oor_ready", {31'd0, b_up_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    b_up_valid = 1'b0;
    chk("oor_err", {31'd0, b_err}, 32'd1);
    chk("oor_valid", {29'd0, b_dn_valid}, 32'd0);
    chk("oor_cnt", {16'd0, b_beat_cnt}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("oor_err_clear", {31'd0, b_err}, 32'd0);
    b_up_sel = 2'd2; b_up_data = 8'h77; b_up_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    b_up_valid = 1'b0;
    chk("n3_valid", {29'd0, b_dn_valid}, 32'h4);
    chk("n3_data", {24'd0, b_dn_data[2]}, 32'h77);
    chk("n3_cnt", {16'd0, b_beat_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
